// File: rtl/mem_burst_responder.sv
// Memory-side responder for cache line-fill / write-back bursts.
// Serves one BURST_LEN-word line per request after a fixed access latency.
//
// state   | meaning
// S_IDLE  | ready, accepts a request
// S_WAIT  | access latency countdown
// S_READ  | streams one line word per cycle on rdata/rvalid
// S_WRITE | accepts line words on wvalid, stalls while wvalid=0

module mem_burst_responder #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32,
   parameter int BURST_LEN  = 4,
   parameter int LATENCY    = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  wvalid,
   output logic                  wready,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  rvalid,
   output logic                  done,
   output logic                  busy
);

   localparam int OFF = $clog2(BURST_LEN);
   localparam int LW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [OFF:0]            LAST     = (OFF+1)'(BURST_LEN - 1);
   localparam logic [LW-1:0]           LAT_LOAD = LW'(LATENCY - 1);
   localparam logic [ADDR_WIDTH-1:0]   ALIGN    = ~ADDR_WIDTH'(BURST_LEN - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READ, S_WRITE} state_t;

   state_t                  state;
   logic [OFF:0]            beat;
   logic [LW-1:0]           lat_cnt;
   logic [ADDR_WIDTH-1:0]   base;
   logic                    we_l;
   logic [DATA_WIDTH-1:0]   mem [2**ADDR_WIDTH];

   logic                    last_beat;
   logic                    wr_en;
   logic [OFF-1:0]          off_nxt;
   logic [ADDR_WIDTH-1:0]   beat_addr;
   logic [ADDR_WIDTH-1:0]   nxt_addr;

   // Only the low OFF bits of beat reach the address, so a burst never leaves its line.
   assign last_beat = (beat == LAST);
   assign wr_en     = (state == S_WRITE) && wvalid;
   assign off_nxt   = beat[OFF-1:0] + OFF'(1);
   assign beat_addr = base | ADDR_WIDTH'(beat[OFF-1:0]);
   assign nxt_addr  = base | ADDR_WIDTH'(off_nxt);
   assign done      = ((state == S_READ) && last_beat) || (wr_en && last_beat);

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[beat_addr] <= wdata;
   end

   // rdata is registered one word ahead so it lines up with rvalid and holds after the burst.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         beat      <= '0;
         lat_cnt   <= '0;
         base      <= '0;
         we_l      <= 1'b0;
         req_ready <= 1'b1;
         busy      <= 1'b0;
         rvalid    <= 1'b0;
         wready    <= 1'b0;
         rdata     <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  base      <= req_addr & ALIGN;
                  we_l      <= req_we;
                  lat_cnt   <= LAT_LOAD;
                  state     <= S_WAIT;
                  req_ready <= 1'b0;
                  busy      <= 1'b1;
               end
            end
            S_WAIT: begin
               if (lat_cnt == '0) begin
                  beat <= '0;
                  if (we_l) begin
                     state  <= S_WRITE;
                     wready <= 1'b1;
                  end else begin
                     state  <= S_READ;
                     rvalid <= 1'b1;
                     rdata  <= mem[base];
                  end
               end else begin
                  lat_cnt <= lat_cnt - LW'(1);
               end
            end
            S_READ: begin
               if (last_beat) begin
                  state     <= S_IDLE;
                  rvalid    <= 1'b0;
                  busy      <= 1'b0;
                  req_ready <= 1'b1;
               end else begin
                  beat  <= beat + (OFF+1)'(1);
                  rdata <= mem[nxt_addr];
               end
            end
            S_WRITE: begin
               if (wvalid) begin
                  if (last_beat) begin
                     state     <= S_IDLE;
                     wready    <= 1'b0;
                     busy      <= 1'b0;
                     req_ready <= 1'b1;
                  end else begin
                     beat <= beat + (OFF+1)'(1);
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_burst_responder.sv
// Bench for mem_burst_responder: LATENCY=3 and LATENCY=1 instances checked
// against a word-level reference memory and cycle-count expectations.

module tb_mem_burst_responder;

   localparam int AW = 10;
   localparam int DW = 32;
   localparam int BL = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          req_valid, req_we, wvalid;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] wdata;
   int            sel;

   logic          rq_v [2];
   logic          wv_g [2];
   logic          rr [2], wr [2], rv [2], dn [2], bz [2];
   logic [DW-1:0] rd [2];

   int n_checks = 0;
   int n_fail   = 0;
   logic [DW-1:0] ref_mem [int];

   always #5 clk = ~clk;

   assign rq_v[0] = req_valid && (sel == 0);
   assign rq_v[1] = req_valid && (sel == 1);
   assign wv_g[0] = wvalid && (sel == 0);
   assign wv_g[1] = wvalid && (sel == 1);

   mem_burst_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL), .LATENCY(3)) u_dut (
      .clk(clk), .reset(reset), .req_valid(rq_v[0]), .req_ready(rr[0]), .req_we(req_we),
      .req_addr(req_addr), .wdata(wdata), .wvalid(wv_g[0]), .wready(wr[0]), .rdata(rd[0]),
      .rvalid(rv[0]), .done(dn[0]), .busy(bz[0]));

   mem_burst_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL), .LATENCY(1)) u_dut_lat1 (
      .clk(clk), .reset(reset), .req_valid(rq_v[1]), .req_ready(rr[1]), .req_we(req_we),
      .req_addr(req_addr), .wdata(wdata), .wvalid(wv_g[1]), .wready(wr[1]), .rdata(rd[1]),
      .rvalid(rv[1]), .done(dn[1]), .busy(bz[1]));

   function automatic int key(input int s, input logic [AW-1:0] a);
      return s * 1024 + int'(a);
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s (dut %0d): got %0h, expected %0h at %0t", tag, sel, got, exp, $time);
      end
   endtask

   // Entered and left at a falling edge. mode 0: wvalid always 1, 1: pattern pat, 2: random.
   task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] d [BL],
                           input int mode, input logic [15:0] pat, input int abort_at);
      logic [AW-1:0] base;
      int idx, cyc, lat, nbeats;
      logic wv;
      base   = {addr[AW-1:2], 2'b00};
      lat    = (sel == 1) ? 1 : 3;
      nbeats = (abort_at < BL) ? abort_at : BL;
      req_valid = 1'b1; req_we = 1'b1; req_addr = addr;
      #1 check("wr_accept_ready", rr[sel], 1'b1);
      @(posedge clk);
      for (int c = 0; c < lat; c++) begin
         @(negedge clk);
         req_valid = 1'b0;
         #1;
         check("wr_wait_wready", wr[sel], 1'b0);
         check("wr_wait_busy", bz[sel], 1'b1);
         check("wr_wait_req_ready", rr[sel], 1'b0);
         @(posedge clk);
      end
      idx = 0; cyc = 0;
      while (idx < nbeats && cyc < 64) begin
         @(negedge clk);
         case (mode)
            0:       wv = 1'b1;
            1:       wv = (cyc < 16) ? pat[cyc] : 1'b1;
            default: wv = ($urandom_range(0, 2) != 0);
         endcase
         wvalid = wv;
         wdata  = wv ? d[idx] : DW'($urandom);
         #1;
         check("wr_wready", wr[sel], 1'b1);
         check("wr_done", dn[sel], wv && (idx == BL - 1));
         @(posedge clk);
         if (wv) begin
            ref_mem[key(sel, base + AW'(idx))] = d[idx];
            idx++;
         end
         cyc++;
      end
      @(negedge clk);
      wvalid = 1'b0;
      check("wr_beats_taken", idx, nbeats);
      if (abort_at >= BL) begin
         #1;
         check("wr_end_req_ready", rr[sel], 1'b1);
         check("wr_end_busy", bz[sel], 1'b0);
         check("wr_end_wready", wr[sel], 1'b0);
         check("wr_end_done", dn[sel], 1'b0);
      end
   endtask

   // hold_req keeps req_valid high throughout; poke_w toggles wvalid with junk data.
   task automatic do_read(input logic [AW-1:0] addr, input bit hold_req, input bit poke_w);
      logic [AW-1:0] base;
      logic [DW-1:0] last;
      bit last_known;
      int lat, k;
      base = {addr[AW-1:2], 2'b00};
      lat  = (sel == 1) ? 1 : 3;
      last = '0; last_known = 0;
      req_valid = 1'b1; req_we = 1'b0; req_addr = addr;
      #1 check("rd_accept_ready", rr[sel], 1'b1);
      @(posedge clk);
      for (int c = 0; c < lat; c++) begin
         @(negedge clk);
         req_valid = hold_req;
         if (poke_w) begin wvalid = 1'($urandom_range(0, 1)); wdata = DW'($urandom); end
         #1;
         check("rd_wait_rvalid", rv[sel], 1'b0);
         check("rd_wait_busy", bz[sel], 1'b1);
         check("rd_wait_req_ready", rr[sel], 1'b0);
         check("rd_wait_done", dn[sel], 1'b0);
         @(posedge clk);
      end
      for (int i = 0; i < BL; i++) begin
         @(negedge clk);
         if (poke_w) begin wvalid = 1'($urandom_range(0, 1)); wdata = DW'($urandom); end
         #1;
         check("rd_rvalid", rv[sel], 1'b1);
         check("rd_done", dn[sel], i == BL - 1);
         check("rd_req_ready", rr[sel], 1'b0);
         k = key(sel, base + AW'(i));
         if (ref_mem.exists(k)) begin
            check("rd_rdata", rd[sel], ref_mem[k]);
            last = ref_mem[k]; last_known = 1;
         end else begin
            last_known = 0;
         end
         @(posedge clk);
      end
      @(negedge clk);
      wvalid = 1'b0;
      if (!hold_req) req_valid = 1'b0;
      #1;
      check("rd_end_rvalid", rv[sel], 1'b0);
      check("rd_end_done", dn[sel], 1'b0);
      check("rd_end_req_ready", rr[sel], 1'b1);
      check("rd_end_busy", bz[sel], 1'b0);
      if (last_known) check("rd_end_rdata_held", rd[sel], last);
   endtask

   logic [DW-1:0] dat [BL];
   logic [DW-1:0] old [BL];
   logic [AW-1:0] ra;

   initial begin
      reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
      wdata = '0; wvalid = 1'b0; sel = 0;

      // async reset between clock edges
      #2 reset = 1'b1;
      #1;
      for (int s = 0; s < 2; s++) begin
         sel = s;
         check("rst_req_ready", rr[s], 1'b1);
         check("rst_busy", bz[s], 1'b0);
         check("rst_rvalid", rv[s], 1'b0);
         check("rst_wready", wr[s], 1'b0);
         check("rst_done", dn[s], 1'b0);
         check("rst_rdata", rd[s], '0);
      end
      sel = 0;
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < BL; i++) dat[i] = 32'hA000_0000 + DW'(i);
      do_write(10'h010, dat, 0, 16'h0, BL);
      do_read(10'h013, 1'b0, 1'b0);

      for (int i = 0; i < BL; i++) dat[i] = 32'hB000_0000 + DW'(i);
      do_write(10'h020, dat, 1, 16'h0059, BL);
      do_read(10'h020, 1'b0, 1'b0);

      do_read(10'h011, 1'b1, 1'b1);
      do_read(10'h010, 1'b0, 1'b0);
      do_read(10'h022, 1'b0, 1'b0);

      for (int i = 0; i < BL; i++) old[i] = 32'hD000_0000 + DW'(i);
      do_write(10'h030, old, 0, 16'h0, BL);
      for (int i = 0; i < BL; i++) dat[i] = 32'hC000_0000 + DW'(i);
      do_write(10'h030, dat, 0, 16'h0, 2);
      reset = 1'b1;
      #1;
      check("midrst_req_ready", rr[sel], 1'b1);
      check("midrst_busy", bz[sel], 1'b0);
      check("midrst_wready", wr[sel], 1'b0);
      check("midrst_done", dn[sel], 1'b0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      do_read(10'h030, 1'b0, 1'b0);

      for (int t = 0; t < 6; t++) begin
         ra = AW'($urandom_range(0, 255) * 4 + $urandom_range(0, 3));
         for (int i = 0; i < BL; i++) dat[i] = DW'($urandom);
         do_write(ra, dat, 2, 16'h0, BL);
         do_read({ra[AW-1:2], 2'(t)}, 1'($urandom_range(0, 1)), 1'b1);
      end
      do_read(10'h031, 1'b0, 1'b0);

      sel = 1;
      for (int i = 0; i < BL; i++) dat[i] = 32'hE000_0000 + DW'(i);
      do_write(10'h050, dat, 1, 16'h0059, BL);
      do_read(10'h052, 1'b1, 1'b1);
      do_read(10'h050, 1'b0, 1'b0);
      sel = 0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
